// File: rtl/video_pkg.sv
// Shared video-side constants, FSM state encoding and slot schedule for the
// text line fetcher.
package video_pkg;

    localparam int CHAR_W  = 8;
    localparam int CG_AW   = 11;
    localparam int VRAM_AW = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Slot positions inside one 8-pixel character time
    localparam logic [2:0] SLOT_VA   = 3'd0;
    localparam logic [2:0] SLOT_CODE = 3'd2;
    localparam logic [2:0] SLOT_CG   = 3'd3;
    localparam logic [2:0] SLOT_FONT = 3'd5;
    localparam logic [2:0] SLOT_LOAD = 3'd7;

    // CG ROM address: character code selects the glyph, raster line the row
    function automatic logic [CG_AW-1:0] cg_addr(input logic [CHAR_W-1:0] code,
                                                 input logic [2:0]        ra);
        return {code, ra};
    endfunction

endpackage

// File: rtl/pix_shift8.sv
// 8-bit font row serialiser. A load hands over a new glyph row; the row is
// then emitted MSB first, one pixel per clock enable, with PIX_DE marking
// valid pixels. A flush discards anything in flight.
module pix_shift8
    import video_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [CHAR_W-1:0] i_data,
    output logic              o_pix,
    output logic              o_de
);

    logic [CHAR_W-1:0] r_shift;
    logic [3:0]        r_bits;
    logic              r_pix;
    logic              r_de;

    // Emit one pixel per enable while bits remain; a load may coincide with the last bit of the previous row
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= 8'h00;
            r_bits  <= 4'd0;
            r_pix   <= 1'b0;
            r_de    <= 1'b0;
        end else if (i_ce) begin
            if (i_flush) begin
                r_shift <= 8'h00;
                r_bits  <= 4'd0;
                r_pix   <= 1'b0;
                r_de    <= 1'b0;
            end else begin
                if (r_bits != 4'd0) begin
                    r_pix <= r_shift[CHAR_W-1];
                    r_de  <= 1'b1;
                end else begin
                    r_pix <= 1'b0;
                    r_de  <= 1'b0;
                end
                if (i_load) begin
                    r_shift <= i_data;
                    r_bits  <= 4'd8;
                end else if (r_bits != 4'd0) begin
                    r_shift <= {r_shift[CHAR_W-2:0], 1'b0};
                    r_bits  <= r_bits - 4'd1;
                end else begin
                    r_shift <= r_shift;
                    r_bits  <= r_bits;
                end
            end
        end
    end

    assign o_pix = r_pix;
    assign o_de  = r_de;

endmodule

// File: rtl/text_line_fetch.sv
// Text-mode line fetcher: walks one text row of VRAM, looks up each glyph
// row in the CG ROM and streams the pixels. The LINE_START cycle itself acts
// as slot 0 of column 0, so the first pixel leaves 8 enables after it.
module text_line_fetch
    import video_pkg::*;
#(
    parameter int COLS = 80,
    parameter int AW   = VRAM_AW
) (
    input  logic             VCLK,
    input  logic             RESET_N,
    input  logic             PIX_CE,
    input  logic             LINE_START,
    input  logic [AW-1:0]    ROW_ADDR,
    input  logic [2:0]       RA,
    output logic [AW-1:0]    VA,
    input  logic [7:0]       VDO,
    output logic [CG_AW-1:0] CG_A,
    input  logic [7:0]       CG_D,
    output logic             PIX,
    output logic             PIX_DE,
    output logic             BUSY
);

    localparam int               COL_W    = $clog2(COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_busy;
    logic [2:0]        r_sc;
    logic [COL_W-1:0]  r_col;
    logic [AW-1:0]     r_row_q;
    logic [2:0]        r_ra_q;
    logic [AW-1:0]     r_va;
    logic [CHAR_W-1:0] r_code;
    logic [CHAR_W-1:0] r_font;
    logic [CG_AW-1:0]  r_cga;
    logic              w_start;
    logic              w_load;

    assign w_start = PIX_CE & LINE_START;
    assign w_load  = PIX_CE & ~LINE_START & (r_state == FETCH) & (r_sc == SLOT_LOAD);

    // State register and registered busy flag
    always_ff @(posedge VCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != IDLE);
        end
    end

    // Next-state logic; a LINE_START always (re)starts a fetch
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH: begin
                if (w_start) begin
                    w_next_state = FETCH;
                end else if (PIX_CE && (r_sc == SLOT_LOAD) && (r_col == COL_LAST)) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = FETCH;
                end
            end
            DRAIN: begin
                if (w_start) begin
                    w_next_state = FETCH;
                end else if (PIX_CE && (r_sc == SLOT_LOAD)) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Slot/column counters and the per-slot fetch pipeline
    always_ff @(posedge VCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sc    <= 3'd0;
            r_col   <= '0;
            r_row_q <= '0;
            r_ra_q  <= 3'd0;
            r_va    <= '0;
            r_code  <= 8'h00;
            r_font  <= 8'h00;
            r_cga   <= '0;
        end else if (w_start) begin
            r_sc    <= 3'd1;
            r_col   <= '0;
            r_row_q <= ROW_ADDR;
            r_ra_q  <= RA;
            r_va    <= ROW_ADDR;
        end else if (PIX_CE && (r_state != IDLE)) begin
            r_sc <= r_sc + 3'd1;
            if (r_state == FETCH) begin
                case (r_sc)
                    SLOT_VA:   r_va   <= r_row_q + AW'(r_col);
                    SLOT_CODE: r_code <= VDO;
                    SLOT_CG:   r_cga  <= cg_addr(r_code, r_ra_q);
                    SLOT_FONT: r_font <= CG_D;
                    SLOT_LOAD: begin
                        if (r_col != COL_LAST) begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    pix_shift8 u_shift (
        .i_clk   (VCLK),
        .i_rst_n (RESET_N),
        .i_ce    (PIX_CE),
        .i_flush (w_start),
        .i_load  (w_load),
        .i_data  (r_font),
        .o_pix   (PIX),
        .o_de    (PIX_DE)
    );

    assign VA   = r_va;
    assign CG_A = r_cga;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_text_line_fetch.sv
// Scoreboard bench for text_line_fetch: one 80-column and one 40-column
// instance share the stimulus; expected pixels and PIX_DE run lengths are
// queued per instance and consumed by a monitor.
module tb_text_line_fetch;

    logic        VCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        PIX_CE = 1'b0;
    logic        LINE_START = 1'b0;
    logic [10:0] ROW_ADDR = 11'h000;
    logic [2:0]  RA = 3'd0;

    logic [10:0] va0, va1, cga0, cga1;
    logic [7:0]  vdo0 = 8'h00, vdo1 = 8'h00, cgd0 = 8'h00, cgd1 = 8'h00;
    logic        pix0, pix1, de0, de1, busy0, busy1;

    logic [7:0]  vram [0:2047];
    bit          rand_mode = 1'b0;
    int          div = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    bit          exp_pix_q [2][$];
    int          exp_run_q [2][$];

    always #5 VCLK = ~VCLK;

    text_line_fetch #(.COLS(80), .AW(11)) u_dut80 (
        .VCLK(VCLK), .RESET_N(RESET_N), .PIX_CE(PIX_CE), .LINE_START(LINE_START),
        .ROW_ADDR(ROW_ADDR), .RA(RA), .VA(va0), .VDO(vdo0), .CG_A(cga0), .CG_D(cgd0),
        .PIX(pix0), .PIX_DE(de0), .BUSY(busy0)
    );

    text_line_fetch #(.COLS(40), .AW(11)) u_dut40 (
        .VCLK(VCLK), .RESET_N(RESET_N), .PIX_CE(PIX_CE), .LINE_START(LINE_START),
        .ROW_ADDR(ROW_ADDR), .RA(RA), .VA(va1), .VDO(vdo1), .CG_A(cga1), .CG_D(cgd1),
        .PIX(pix1), .PIX_DE(de1), .BUSY(busy1)
    );

    function automatic logic [7:0] cg_byte(input logic [10:0] a);
        if (a == 11'h20B) return 8'hA5;
        else return a[7:0] ^ {a[10:8], a[4:0]};
    endfunction

    // Registered VRAM video port and CG ROM models, one per instance
    always @(posedge VCLK) begin
        vdo0 <= rand_mode ? 8'($urandom) : vram[va0];
        vdo1 <= rand_mode ? 8'($urandom) : vram[va1];
        cgd0 <= rand_mode ? 8'($urandom) : cg_byte(cga0);
        cgd1 <= rand_mode ? 8'($urandom) : cg_byte(cga1);
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic chk_both(input string name, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] exp);
        chk(name, 0, a0, exp);
        chk(name, 1, a1, exp);
    endtask

    // Queue the first npix pixels of a text row plus the resulting PIX_DE run length
    task automatic push_line(input int d, input logic [10:0] row, input logic [2:0] ra, input int npix);
        for (int p = 0; p < npix; p++) begin
            logic [10:0] a;
            logic [7:0]  f;
            a = 11'(row + 11'(p / 8));
            f = cg_byte({vram[a], ra});
            exp_pix_q[d].push_back(f[7 - (p % 8)]);
        end
        exp_run_q[d].push_back(npix);
    endtask

    task automatic tick(input bit ce, input bit ls);
        PIX_CE = ce;
        LINE_START = ls;
        @(posedge VCLK);
        @(negedge VCLK);
        LINE_START = 1'b0;
    endtask

    task automatic ce_step(input bit ls);
        tick(1'b1, ls);
        for (int i = 1; i < div; i++) tick(1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 1200) begin
            ce_step(1'b0);
            n++;
        end
        chk_both("busy_timeout", busy0, busy1, 0);
        repeat (3) ce_step(1'b0);
    endtask

    // Monitor: consume queued pixels on enabled cycles, check run lengths and hold behaviour
    logic [1:0]  pix_v, de_v;
    logic [24:0] snap_v [2];
    assign pix_v = {pix1, pix0};
    assign de_v  = {de1, de0};
    assign snap_v[0] = {va0, cga0, pix0, de0, busy0};
    assign snap_v[1] = {va1, cga1, pix1, de1, busy1};

    initial begin
        logic        ce_s, rst_s, prev_rst;
        logic        prev_de [2];
        logic [24:0] prev_snap [2];
        int          run_len [2];
        prev_rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            prev_de[d] = 1'b0; prev_snap[d] = '0; run_len[d] = 0;
        end
        forever begin
            @(posedge VCLK);
            ce_s = PIX_CE;
            rst_s = RESET_N;
            #2;
            for (int d = 0; d < 2; d++) begin
                if (rst_s && prev_rst && !ce_s)
                    chk("hold", d, snap_v[d], prev_snap[d]);
                if (ce_s && de_v[d]) begin
                    run_len[d]++;
                    if (exp_pix_q[d].size() == 0) chk("pix_extra", d, exp_pix_q[d].size(), 1);
                    else chk("pix", d, pix_v[d], exp_pix_q[d].pop_front());
                end else if (!de_v[d]) begin
                    chk("pix_idle", d, pix_v[d], 0);
                end
                if (prev_de[d] && !de_v[d]) begin
                    if (exp_run_q[d].size() == 0) chk("run_extra", d, exp_run_q[d].size(), 1);
                    else chk("de_len", d, run_len[d], exp_run_q[d].pop_front());
                    run_len[d] = 0;
                end
                prev_de[d] = de_v[d];
                prev_snap[d] = snap_v[d];
            end
            prev_rst = rst_s;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        for (int i = 0; i < 2048; i++) vram[i] = 8'(i * 37 + 11);
        vram[11'h100] = 8'h41;

        repeat (3) tick(1'b0, 1'b0);
        RESET_N = 1'b1;
        chk_both("rst_va", va0, va1, 0);
        chk_both("rst_cga", cga0, cga1, 0);
        chk_both("rst_pix", pix0, pix1, 0);
        chk_both("rst_de", de0, de1, 0);
        chk_both("rst_busy", busy0, busy1, 0);

        // Basic line and clock-enable variant
        for (int pass = 0; pass < 2; pass++) begin
            div = pass + 1;
            ROW_ADDR = 11'h100; RA = 3'd3;
            push_line(0, 11'h100, 3'd3, 640);
            push_line(1, 11'h100, 3'd3, 320);
            ce_step(1'b1);
            chk_both("basic_va", va0, va1, 32'h100);
            chk_both("basic_busy", busy0, busy1, 1);
            repeat (3) ce_step(1'b0);
            chk_both("basic_cga", cga0, cga1, 32'h20B);
            repeat (4) ce_step(1'b0);
            chk_both("basic_de_early", de0, de1, 0);
            ce_step(1'b0);
            chk_both("basic_de_first", de0, de1, 1);
            chk_both("basic_pix_first", pix0, pix1, 1);
            wait_idle();
        end
        div = 1;

        // Address wrap
        ROW_ADDR = 11'h7F0; RA = 3'd5;
        push_line(0, 11'h7F0, 3'd5, 640);
        push_line(1, 11'h7F0, 3'd5, 320);
        for (int c = 0; c < 40; c++) begin
            ce_step(c == 0);
            chk_both("wrap_va", va0, va1, 32'((11'h7F0 + c) & 11'h7FF));
            repeat (7) ce_step(1'b0);
        end
        wait_idle();

        // Abort at column 10
        ROW_ADDR = 11'h040; RA = 3'd1;
        push_line(0, 11'h040, 3'd1, 76);
        push_line(1, 11'h040, 3'd1, 76);
        ce_step(1'b1);
        repeat (83) ce_step(1'b0);
        ROW_ADDR = 11'h200; RA = 3'd2;
        push_line(0, 11'h200, 3'd2, 640);
        push_line(1, 11'h200, 3'd2, 320);
        ce_step(1'b1);
        chk_both("abort_de", de0, de1, 0);
        chk_both("abort_va", va0, va1, 32'h200);
        repeat (7) ce_step(1'b0);
        chk_both("abort_de_early", de0, de1, 0);
        ce_step(1'b0);
        chk_both("abort_de_first", de0, de1, 1);
        wait_idle();

        // Asynchronous reset at column 5, slot 4
        ROW_ADDR = 11'h300; RA = 3'd0;
        push_line(0, 11'h300, 3'd0, 36);
        push_line(1, 11'h300, 3'd0, 36);
        ce_step(1'b1);
        repeat (43) ce_step(1'b0);
        #2 RESET_N = 1'b0;
        #1;
        chk_both("arst_va", va0, va1, 0);
        chk_both("arst_cga", cga0, cga1, 0);
        chk_both("arst_pix", pix0, pix1, 0);
        chk_both("arst_de", de0, de1, 0);
        chk_both("arst_busy", busy0, busy1, 0);
        repeat (3) tick(1'b1, 1'b0);
        RESET_N = 1'b1;

        // Idle isolation with garbage on the data inputs
        rand_mode = 1'b1;
        repeat (50) ce_step(1'b0);
        chk_both("idle_busy", busy0, busy1, 0);
        chk_both("idle_va", va0, va1, 0);
        chk_both("idle_de", de0, de1, 0);
        rand_mode = 1'b0;

        repeat (4) tick(1'b1, 1'b0);
        chk_both("pix_q_left", exp_pix_q[0].size(), exp_pix_q[1].size(), 0);
        chk_both("run_q_left", exp_run_q[0].size(), exp_run_q[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
